// File: rtl/sw_in_pkg.sv
// Shared constants for the switch/button input peripheral: register map and bus width.
package sw_in_pkg;

    localparam int SW_IN_DATA_W = 32;

    typedef enum logic [1:0] {
        SW_IN_LEVEL = 2'd0,
        SW_IN_RISE  = 2'd1,
        SW_IN_FALL  = 2'd2,
        SW_IN_MASK  = 2'd3
    } sw_in_reg_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One input bit: two-flop synchronizer, debounce counter and stable level,
// with single-cycle rise/fall pulses aligned to the stable update.
module sw_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 65536,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;

    // The synced value has disagreed long enough; level takes it on this edge.
    assign accept = (s2 != level) && (cnt == CNT_LAST);
    assign rise   = accept & s2;
    assign fall   = accept & ~s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= RESET_LEVEL;
            s2    <= RESET_LEVEL;
            cnt   <= '0;
            level <= RESET_LEVEL;
        end else begin
            // NOTE: non-blocking so s2 takes last cycle's s1, giving two real flop stages.
            s1 <= pin;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_in_reader.sv
// Memory-mapped debounced switch reader: LEVEL, sticky W1C RISE/FALL flags.
// Define SW_IN_IRQ_EN to add the IRQ_MASK register at addr 3 and the irq output.
module sw_in_reader
    import sw_in_pkg::*;
#(
    parameter int             N               = 8,
    parameter int             DEBOUNCE_CYCLES = 65536,
    parameter logic [N-1:0]   RESET_LEVEL     = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            pins_in,
    input  logic                    bus_valid,
    input  logic [1:0]              bus_addr,
    input  logic [3:0]              bus_wstrb,
    input  logic [SW_IN_DATA_W-1:0] bus_wdata,
    output logic [SW_IN_DATA_W-1:0] bus_rdata,
    output logic                    bus_ready
`ifdef SW_IN_IRQ_EN
    ,
    output logic                    irq
`endif
);

    logic [N-1:0]            level;
    logic [N-1:0]            rise_pulse;
    logic [N-1:0]            fall_pulse;
    logic [N-1:0]            rise_q;
    logic [N-1:0]            fall_q;
    logic [N-1:0]            clr_rise;
    logic [N-1:0]            clr_fall;
    logic                    accept;
    logic                    wr;
    logic [SW_IN_DATA_W-1:0] rd_word;
    logic                    unused_wdata;

    for (genvar i = 0; i < N; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (RESET_LEVEL[i])
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .pin  (pins_in[i]),
            .level(level[i]),
            .rise (rise_pulse[i]),
            .fall (fall_pulse[i])
        );
    end

    // While bus_ready is high the master is still dropping valid; ignore it.
    assign accept       = bus_valid & ~bus_ready;
    assign wr           = |bus_wstrb;
    assign clr_rise     = (accept && wr && bus_addr == SW_IN_RISE) ? bus_wdata[N-1:0] : '0;
    assign clr_fall     = (accept && wr && bus_addr == SW_IN_FALL) ? bus_wdata[N-1:0] : '0;
    assign unused_wdata = ^bus_wdata;

`ifdef SW_IN_IRQ_EN
    logic [N-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (accept && wr && bus_addr == SW_IN_MASK) begin
                mask_q <= bus_wdata[N-1:0];
            end
            irq <= |((rise_q | fall_q) & mask_q);
        end
    end
`endif

    always_comb begin
        // NOTE: default first so every path assigns rd_word and no latch is inferred.
        rd_word = '0;
        case (sw_in_reg_e'(bus_addr))
            SW_IN_LEVEL: rd_word[N-1:0] = level;
            SW_IN_RISE:  rd_word[N-1:0] = rise_q;
            SW_IN_FALL:  rd_word[N-1:0] = fall_q;
`ifdef SW_IN_IRQ_EN
            SW_IN_MASK:  rd_word[N-1:0] = mask_q;
`endif
            default:     rd_word = '0;
        endcase
    end

    // A new edge in the same cycle as a clear of that bit leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q    <= '0;
            fall_q    <= '0;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            rise_q    <= (rise_q & ~clr_rise) | rise_pulse;
            fall_q    <= (fall_q & ~clr_fall) | fall_pulse;
            bus_ready <= accept;
            if (accept) begin
                bus_rdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_sw_in_reader.sv
// Randomized scoreboard bench for sw_in_reader (N=8, DEBOUNCE_CYCLES=4);
// also exercises irq when compiled with SW_IN_IRQ_EN.
module tb_sw_in_reader;
    import sw_in_pkg::*;

    localparam int N  = 8;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pins_in;
    logic         bus_valid;
    logic [1:0]   bus_addr;
    logic [3:0]   bus_wstrb;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_ready;
`ifdef SW_IN_IRQ_EN
    logic         irq;
`endif

    sw_in_reader #(
        .N              (N),
        .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL    (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pins_in  (pins_in),
        .bus_valid(bus_valid),
        .bus_addr (bus_addr),
        .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready)
`ifdef SW_IN_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Reference model: pins reach the debouncer two edges late; a bit's level
    // flips once the delayed pin has disagreed with it on DC consecutive edges.
    logic [N-1:0] m_d1, m_d2, m_stable, m_rise, m_fall, m_mask;
    int           m_run [N];
    logic         m_ready, m_irq;
    logic [31:0]  exp_q [$];

    always @(posedge clk) begin : model
        logic [N-1:0] nstable, clr_r, clr_f;
        logic [31:0]  rd;
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_stable = '0;
            m_rise = '0; m_fall = '0; m_mask = '0;
            m_ready = 1'b0; m_irq = 1'b0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            exp_q.delete();
        end else begin
            nstable = m_stable;
            for (int i = 0; i < N; i++) begin
                if (m_d2[i] == m_stable[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        nstable[i] = m_d2[i];
                        m_run[i]   = 0;
                    end
                end
            end
            clr_r = '0;
            clr_f = '0;
            if (bus_valid && !m_ready) begin
                case (bus_addr)
                    2'd0:    rd = {24'h0, m_stable};
                    2'd1:    rd = {24'h0, m_rise};
                    2'd2:    rd = {24'h0, m_fall};
`ifdef SW_IN_IRQ_EN
                    default: rd = {24'h0, m_mask};
`else
                    default: rd = 32'h0;
`endif
                endcase
                exp_q.push_back(rd);
                if (bus_wstrb != 4'h0) begin
                    if (bus_addr == 2'd1) clr_r = bus_wdata[N-1:0];
                    if (bus_addr == 2'd2) clr_f = bus_wdata[N-1:0];
`ifdef SW_IN_IRQ_EN
                    if (bus_addr == 2'd3) m_mask = bus_wdata[N-1:0];
`endif
                end
                m_ready = 1'b1;
            end else begin
                m_ready = 1'b0;
            end
`ifdef SW_IN_IRQ_EN
            // irq follows the flag/mask state from before this edge.
            m_irq = |((m_rise | m_fall) & m_mask_prev(m_mask, bus_valid, bus_addr, bus_wstrb));
`endif
            m_rise   = (m_rise & ~clr_r) | (nstable & ~m_stable);
            m_fall   = (m_fall & ~clr_f) | (~nstable & m_stable);
            m_stable = nstable;
            m_d2     = m_d1;
            m_d1     = pins_in;
        end
    end

`ifdef SW_IN_IRQ_EN
    // Mask as it was before this edge: undo a mask write the model just applied.
    logic [N-1:0] mask_before;
    always @(negedge clk) mask_before = m_mask;
    function automatic logic [N-1:0] m_mask_prev(input logic [N-1:0] cur, input logic v,
                                                 input logic [1:0] a, input logic [3:0] s);
        return mask_before;
    endfunction
`endif

    // Monitor: pops one expected word whenever the DUT completes an access.
    always @(negedge clk) begin
        check("bus_ready", {31'h0, bus_ready}, {31'h0, m_ready});
        if (bus_ready) begin
            if (exp_q.size() == 0) check("unexpected_ready", 32'h1, 32'h0);
            else check("bus_rdata", bus_rdata, exp_q.pop_front());
        end
`ifdef SW_IN_IRQ_EN
        check("irq", {31'h0, irq}, {31'h0, m_irq});
`endif
    end

    task automatic bus_op(input logic [1:0] a, input logic w, input logic [31:0] d);
        bit done = 0;
        @(negedge clk);
        bus_valid = 1'b1;
        bus_addr  = a;
        bus_wstrb = w ? 4'($urandom_range(1, 15)) : 4'h0;
        bus_wdata = w ? d : $urandom;
        for (int k = 0; k < 4 && !done; k++) begin
            @(negedge clk);
            if (bus_ready) done = 1;
        end
        if (!done) check("ready_timeout", 32'h0, 32'h1);
        bus_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pins_in = '0; bus_valid = 1'b0;
        bus_addr = '0; bus_wstrb = '0; bus_wdata = '0;
        idle(3);
        check("reset_rdata", bus_rdata, 32'h0);
        check("reset_ready", {31'h0, bus_ready}, 32'h0);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) bus_op(2'(a), 1'b0, 32'h0);

        // Clean press on bit 2, reads at both cycle parities around the update.
        pins_in[2] = 1'b1;
        for (int k = 0; k < 5; k++) bus_op(2'd0, 1'b0, 32'h0);
        idle(1);
        for (int k = 0; k < 3; k++) bus_op(2'd0, 1'b0, 32'h0);
        bus_op(2'd1, 1'b0, 32'h0);

        // Glitch of 3 cycles on bit 5 is rejected; 4 cycles is accepted.
        pins_in[5] = 1'b1; idle(3); pins_in[5] = 1'b0;
        idle(6);
        for (int a = 0; a < 3; a++) bus_op(2'(a), 1'b0, 32'h0);
        pins_in[5] = 1'b1; idle(4); pins_in[5] = 1'b0;
        idle(6);
        for (int a = 0; a < 3; a++) bus_op(2'(a), 1'b0, 32'h0);

        // W1C of bit 2, then a clear of bit 5 colliding with a new rise.
        bus_op(2'd1, 1'b1, 32'h04);
        bus_op(2'd1, 1'b0, 32'h0);
        bus_op(2'd1, 1'b1, 32'h20);
        bus_op(2'd1, 1'b0, 32'h0);
        pins_in[5] = 1'b1;
        idle(4);
        bus_op(2'd1, 1'b1, 32'h20);
        bus_op(2'd1, 1'b0, 32'h0);

        // Release bit 2, then reset bit 3 mid-count.
        pins_in[2] = 1'b0;
        idle(8);
        bus_op(2'd2, 1'b0, 32'h0);
        pins_in[3] = 1'b1;
        idle(4);
        rst = 1'b1; idle(1); rst = 1'b0;
        for (int k = 0; k < 6; k++) bus_op(2'(k % 3), 1'b0, 32'h0);

`ifdef SW_IN_IRQ_EN
        bus_op(2'd1, 1'b1, 32'hFF);
        bus_op(2'd2, 1'b1, 32'hFF);
        bus_op(2'd3, 1'b1, 32'h01);
        pins_in[0] = 1'b1; idle(10);
        bus_op(2'd1, 1'b1, 32'h01); idle(3);
        pins_in[1] = 1'b1; idle(10);
        bus_op(2'd3, 1'b0, 32'h0);
`endif

        for (int it = 0; it < 250; it++) begin
            int b;
            b = $urandom_range(0, N - 1);
            if ($urandom_range(0, 9) < 4) pins_in[b] = ~pins_in[b];
            bus_op(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), $urandom);
            idle($urandom_range(0, DC + 3));
        end

        idle(2);
        check("queue_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
